seg_pattern_encoder: RTL and testbench

//  Inverse of the display decoder: turns active-low 7-segment patterns
//  (bit6=g .. bit0=a) back into the 5-bit display character code.

---
 rtl/seg_pattern_encoder.sv | 108 ++++++++++
 tb/tb_seg_pattern_encoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_pattern_encoder.sv
// Active-low 7-segment pattern to 5-bit character code encoder.
// A valid/ready input feeds an output FIFO; unrecognised patterns are flagged and counted.
module seg_pattern_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_in,
  input  logic                 seg_valid,
  output logic                 seg_ready,
  output logic [4:0]           code_out,
  output logic                 code_err,
  output logic                 code_valid,
  input  logic                 code_ready,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = 6;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_next_c;
  logic [CNT_W-1:0]   count, count_next_c, count_after_pop_c;
  logic [4:0]         lut_code_c;
  logic               lut_err_c;
  logic               push_c, pop_c;
  logic [ENTRY_W-1:0] head_next_c;

  // Pattern lookup; 0010010 is shared by 5 and S and always encodes as 5.
  always_comb begin
    lut_code_c = 5'd0;
    lut_err_c  = 1'b0;
    case (seg_in)
      7'b1000000: lut_code_c = 5'b00000;
      7'b1111001: lut_code_c = 5'b00001;
      7'b0100100: lut_code_c = 5'b00010;
      7'b0110000: lut_code_c = 5'b00011;
      7'b0011001: lut_code_c = 5'b00100;
      7'b0010010: lut_code_c = 5'b00101;
      7'b0000010: lut_code_c = 5'b00110;
      7'b1111000: lut_code_c = 5'b00111;
      7'b0000000: lut_code_c = 5'b01000;
      7'b0010000: lut_code_c = 5'b01001;
      7'b0001000: lut_code_c = 5'b01010;
      7'b0000011: lut_code_c = 5'b01011;
      7'b1000110: lut_code_c = 5'b01100;
      7'b0100001: lut_code_c = 5'b01101;
      7'b0000110: lut_code_c = 5'b01110;
      7'b0001110: lut_code_c = 5'b01111;
      7'b1000010: lut_code_c = 5'b10000;
      7'b0001001: lut_code_c = 5'b10001;
      7'b1001111: lut_code_c = 5'b10010;
      7'b1000111: lut_code_c = 5'b10011;
      7'b1101010: lut_code_c = 5'b10100;
      7'b0001100: lut_code_c = 5'b10101;
      7'b0000111: lut_code_c = 5'b10111;
      7'b1000001: lut_code_c = 5'b11000;
      7'b0111111: lut_code_c = 5'b11001;
      default:    lut_err_c  = 1'b1;
    endcase
  end

  // FIFO bookkeeping; the head register is loaded straight from the lookup when the
  // queue is (or becomes) empty so an empty FIFO has one clock of latency.
  always_comb begin
    push_c            = seg_valid && seg_ready;
    pop_c             = code_valid && code_ready;
    rd_ptr_next_c     = rd_ptr + PTR_W'(pop_c);
    count_after_pop_c = count - CNT_W'(pop_c);
    count_next_c      = count_after_pop_c + CNT_W'(push_c);
    if (push_c && (count_after_pop_c == '0))
      head_next_c = {lut_err_c, lut_code_c};
    else
      head_next_c = mem[rd_ptr_next_c];
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {lut_err_c, lut_code_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seg_ready  <= 1'b0;
      code_valid <= 1'b0;
      code_out   <= 5'd0;
      code_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_next_c;
      count      <= count_next_c;
      seg_ready  <= (count_next_c != CNT_W'(DEPTH));
      code_valid <= (count_next_c != '0);
      if (count_next_c != '0) {code_err, code_out} <= head_next_c;
      if (clr_err)
        err_count <= '0;
      else if (push_c && lut_err_c && (err_count != '1))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seg_pattern_encoder.sv
// Self-checking bench for seg_pattern_encoder: directed scenarios then random traffic
// against a queue-based reference model.
module tb_seg_pattern_encoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       seg_valid, seg_ready;
  logic [4:0] code_out;
  logic       code_err, code_valid, code_ready, clr_err;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  seg_pattern_encoder #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_valid(seg_valid),
    .seg_ready(seg_ready), .code_out(code_out), .code_err(code_err),
    .code_valid(code_valid), .code_ready(code_ready), .clr_err(clr_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [25] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                           7'h42, 7'h09, 7'h4F, 7'h47, 7'h6A, 7'h0C, 7'h07, 7'h41, 7'h3F};
  int cod [25] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                   16, 17, 18, 19, 20, 21, 23, 24, 25};

  // Reference model state: queued {err,code} entries, ready flag, error count.
  int q[$];
  bit exp_ready;
  int exp_cnt;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 25; i++)
      if (pat[i] == p) return cod[i];
    return 32;  // bit5 = error flag, code 0
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ready"}, int'(seg_ready), int'(exp_ready));
    chk({tag, ".valid"}, int'(code_valid), int'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".head"}, int'({code_err, code_out}), q[0]);
    chk({tag, ".errcnt"}, int'(err_count), exp_cnt);
  endtask

  task automatic model_reset();
    q.delete();
    exp_ready = 1'b0;
    exp_cnt   = 0;
  endtask

  // One clock: drive inputs, advance model on the edge, check 1 time unit later.
  task automatic step(input string tag, input logic [6:0] s, input logic v,
                      input logic cr, input logic clr);
    bit acc, pp;
    int e;
    seg_in = s; seg_valid = v; code_ready = cr; clr_err = clr;
    @(posedge clk);
    acc = v && exp_ready;
    pp  = (q.size() != 0) && cr;
    e   = lookup(s);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (clr) exp_cnt = 0;
    else if (acc && e >= 32 && exp_cnt < 255) exp_cnt++;
    exp_ready = (q.size() < DEPTH);
    #1;
    chk_all(tag);
  endtask

  initial begin
    seg_in = 7'h7F; seg_valid = 1'b0; code_ready = 1'b0; clr_err = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst.valid", int'(code_valid), 0);
    chk("rst.code", int'(code_out), 0);
    chk("rst.err", int'(code_err), 0);
    chk("rst.errcnt", int'(err_count), 0);
    chk("rst.ready", int'(seg_ready), 0);
    rst_n = 1'b1;
    step("idle", 7'h7F, 1'b0, 1'b0, 1'b0);

    // Single push: digit 3 appears next cycle.
    step("t1.push", 7'h30, 1'b1, 1'b0, 1'b0);
    chk("t1.code3", int'(code_out), 3);
    step("t1.pop", 7'h7F, 1'b0, 1'b1, 1'b0);

    // Fill to full under stall, then drain in order.
    step("t2.p1", 7'h79, 1'b1, 1'b0, 1'b0);
    step("t2.p2", 7'h24, 1'b1, 1'b0, 1'b0);
    step("t2.p3", 7'h19, 1'b1, 1'b0, 1'b0);
    step("t2.p4", 7'h12, 1'b1, 1'b0, 1'b0);
    chk("t2.full", int'(seg_ready), 0);
    step("t2.blocked", 7'h30, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("t2.drain", 7'h7F, 1'b0, 1'b1, 1'b0);

    // Unrecognised patterns and clear priority.
    step("t3.bad1", 7'h7F, 1'b1, 1'b1, 1'b0);
    step("t3.bad2", 7'h55, 1'b1, 1'b1, 1'b0);
    chk("t3.cnt2", int'(err_count), 2);
    step("t3.clr", 7'h7F, 1'b1, 1'b1, 1'b1);
    chk("t3.cnt0", int'(err_count), 0);

    // Saturation.
    for (int i = 0; i < 260; i++) step("t4.sat", 7'h7F, 1'b1, 1'b1, 1'b0);
    chk("t4.cnt255", int'(err_count), 255);
    step("t4.clr", 7'h7F, 1'b0, 1'b1, 1'b1);

    // Full table streamed back-to-back.
    for (int i = 0; i < 25; i++) step("t5.table", pat[i], 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("t5.flush", 7'h7F, 1'b0, 1'b1, 1'b0);

    // Reset with entries queued.
    for (int i = 0; i < 3; i++) step("t6.fill", pat[i], 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6.valid_in_rst", int'(code_valid), 0);
    model_reset();
    #2 rst_n = 1'b1;
    step("t6.after", 7'h7F, 1'b0, 1'b1, 1'b0);
    chk("t6.empty", int'(code_valid), 0);

    // Random traffic: mostly table patterns, some arbitrary ones.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] s;
      if ($urandom_range(0, 3) == 0) s = 7'($urandom);
      else s = pat[$urandom_range(0, 24)];
      step("rand", s, 1'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
